// File: rtl/seven_seg_pkg.sv
// Shared seven-segment constants: active-low segment encodings (bit6 = a ... bit0 = g)
// and the hex decode helper used by the scan driver's decoder.
package seven_seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    return SEG_TABLE[hex];
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
  import seven_seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(hex);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed seven-segment scan driver: double-buffered digit image, leading-zero
// suppression, per-slot anode blanking and registered active-low outputs.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic                  lz_suppress,
  input  logic                  load,
  output logic [6:0]            segments,
  output logic                  dp_out,
  output logic [N_DIGITS-1:0]   anodes,
  output logic                  frame_start
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [CW-1:0]       CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]       BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0]       IDX_LAST  = IW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] ANODE_ONE = N_DIGITS'(1);

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          tick;
  logic          frame_end;
  logic          pending;

  logic [4*N_DIGITS-1:0] stage_digits, disp_digits;
  logic [N_DIGITS-1:0]   stage_dp, disp_dp;
  logic [N_DIGITS-1:0]   stage_blank, disp_blank;
  logic                  stage_lz, disp_lz;

  logic [N_DIGITS-1:0] suppress;
  logic                zero_above;
  logic [3:0]          cur_hex;
  logic [6:0]          seg_raw;
  logic                dark;

  assign tick      = (cnt == CNT_LAST);
  assign frame_end = tick && (idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      idx          <= '0;
      pending      <= 1'b0;
      stage_digits <= '0;
      stage_dp     <= '0;
      stage_blank  <= '0;
      stage_lz     <= 1'b0;
      disp_digits  <= '0;
      disp_dp      <= '0;
      disp_blank   <= '0;
      disp_lz      <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end

      if (load) begin
        stage_digits <= digits_in;
        stage_dp     <= dp_in;
        stage_blank  <= blank_in;
        stage_lz     <= lz_suppress;
      end

      // A load landing on frame_end bypasses staging so it shows in the very next slot.
      if (frame_end && load) begin
        disp_digits <= digits_in;
        disp_dp     <= dp_in;
        disp_blank  <= blank_in;
        disp_lz     <= lz_suppress;
        pending     <= 1'b0;
      end else if (frame_end && pending) begin
        disp_digits <= stage_digits;
        disp_dp     <= stage_dp;
        disp_blank  <= stage_blank;
        disp_lz     <= stage_lz;
        pending     <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // Scan from the most significant digit down; digit 0 is never suppressed.
  always_comb begin
    zero_above = 1'b1;
    suppress   = '0;
    for (int unsigned k = N_DIGITS - 1; k >= 1; k--) begin
      if (disp_digits[4*k +: 4] != 4'h0) begin
        zero_above = 1'b0;
      end
      suppress[k] = disp_lz & zero_above;
    end
  end

  assign cur_hex = disp_digits[{idx, 2'b00} +: 4];
  assign dark    = disp_blank[idx] | suppress[idx];

  hex_to_seg7 u_hex_to_seg7 (
    .hex (cur_hex),
    .seg (seg_raw)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      segments    <= SEG_OFF;
      dp_out      <= 1'b1;
      anodes      <= '1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= (cnt == '0) && (idx == '0);
      anodes      <= (cnt < BLANK_END) ? '1 : ~(ANODE_ONE << idx);
      segments    <= dark ? SEG_OFF : seg_raw;
      dp_out      <= dark ? 1'b1 : ~disp_dp[idx];
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench for seven_seg_scan_driver: a frame-level reference model predicts
// every registered output cycle; a monitor pops and compares one entry per clock.
module tb_seven_seg_scan_driver;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int P  = N * RD;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [4*N-1:0] digits_in = '0;
  logic [N-1:0]   dp_in = '0;
  logic [N-1:0]   blank_in = '0;
  logic           lz_suppress = 1'b0;
  logic           load = 1'b0;
  logic [6:0]     segments;
  logic           dp_out;
  logic [N-1:0]   anodes;
  logic           frame_start;

  seven_seg_scan_driver #(
    .N_DIGITS     (N),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .digits_in   (digits_in),
    .dp_in       (dp_in),
    .blank_in    (blank_in),
    .lz_suppress (lz_suppress),
    .load        (load),
    .segments    (segments),
    .dp_out      (dp_out),
    .anodes      (anodes),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]   seg;
    logic         dp;
    logic [N-1:0] an;
    logic         fs;
  } out_t;

  typedef struct {
    logic [4*N-1:0] d;
    logic [N-1:0]   dp;
    logic [N-1:0]   bl;
    logic           lz;
  } img_t;

  out_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   t = 0;
  int   cyc = 0;
  img_t latest, shown;

  logic [6:0] font [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // t counts evaluated cycles since reset release; the image shown in a frame is the
  // most recent load issued strictly before that frame's first cycle.
  function automatic out_t model_eval(int tt, img_t s);
    out_t           o;
    int             cnt, idx;
    logic [4*N-1:0] upper;
    cnt   = tt % RD;
    idx   = (tt / RD) % N;
    o.fs  = (tt % P == 0);
    o.an  = (cnt < BC) ? '1 : ~(N'(1) << idx);
    upper = s.d >> (4 * idx);
    if (s.bl[idx] || (s.lz && idx >= 1 && upper == '0)) begin
      o.seg = 7'b1111111;
      o.dp  = 1'b1;
    end else begin
      o.seg = font[upper[3:0]];
      o.dp  = ~s.dp[idx];
    end
    return o;
  endfunction

  task automatic step();
    out_t e;
    if (reset) begin
      e.seg  = 7'b1111111;
      e.dp   = 1'b1;
      e.an   = '1;
      e.fs   = 1'b0;
      t      = 0;
      latest = '{default: '0};
      shown  = '{default: '0};
    end else begin
      if (t % P == 0) shown = latest;
      e = model_eval(t, shown);
      if (load) latest = '{d: digits_in, dp: dp_in, bl: blank_in, lz: lz_suppress};
      t++;
    end
    exp_q.push_back(e);
    @(negedge clk);
    load = 1'b0;
    cyc++;
  endtask

  task automatic apply_load(input logic [4*N-1:0] d, input logic [N-1:0] dp,
                            input logic [N-1:0] bl, input logic lz);
    digits_in   = d;
    dp_in       = dp;
    blank_in    = bl;
    lz_suppress = lz;
    load        = 1'b1;
    step();
  endtask

  task automatic run_until(input int phase);
    for (int i = 0; i < P && (t % P) != phase; i++) step();
  endtask

  out_t got, want;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got  = {segments, dp_out, anodes, frame_start};
        checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL outputs cyc=%0d: got seg=%b dp=%b an=%b fs=%b, want seg=%b dp=%b an=%b fs=%b",
                   cyc, got.seg, got.dp, got.an, got.fs, want.seg, want.dp, want.an, want.fs);
        end
      end
    end
  end

  initial begin
    @(negedge clk);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    repeat (P + 4) step();

    apply_load(16'h12AF, 4'b0000, 4'b0000, 1'b0);
    repeat (2 * P) step();

    apply_load(16'h0050, 4'b0000, 4'b0000, 1'b1);
    repeat (2 * P) step();
    apply_load(16'h0000, 4'b0000, 4'b0000, 1'b1);
    repeat (2 * P) step();

    run_until(10);
    apply_load(16'h3456, 4'b0000, 4'b0000, 1'b0);
    repeat (P / 2) step();
    apply_load(16'hC0DE, 4'b0011, 4'b0000, 1'b0);
    run_until(P - 1);
    apply_load(16'h789B, 4'b0000, 4'b0000, 1'b0);
    repeat (P + 2) step();

    apply_load(16'h1234, 4'b0100, 4'b0001, 1'b0);
    repeat (2 * P) step();

    run_until(2 * RD + 4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (2 * P) step();

    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < N; k++) begin
        digits_in[4*k +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
      end
      dp_in       = N'($urandom);
      blank_in    = N'($urandom) & N'($urandom);
      lz_suppress = 1'($urandom);
      load        = ($urandom_range(0, 15) == 0);
      reset       = ($urandom_range(0, 499) == 0);
      step();
      reset = 1'b0;
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    checks++;
    if (checks < 3000) begin
      failures++;
      $display("FAIL coverage: got %0d comparisons, want at least 3000", checks);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_driver.md
SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 SHALL have parameter N_DIGITS, default 8, number of multiplexed digits (2..16).
REQ-002 SHALL have parameter REFRESH_DIV, default 100000, clock cycles per digit slot (>= 4).
REQ-003 SHALL have parameter BLANK_CYCLES, default 1000, anode-off cycles at start of each slot (< REFRESH_DIV).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port digits_in  input  4*N_DIGITS  hex nibbles; nibble k drives digit k; digit 0 is rightmost.
REQ-007 SHALL have port dp_in  input  N_DIGITS  decimal point request per digit, 1 = lit.
REQ-008 SHALL have port blank_in  input  N_DIGITS  forced blank per digit, 1 = dark.
REQ-009 SHALL have port lz_suppress  input  1  leading-zero suppression enable.
REQ-010 SHALL have port load  input  1  one-cycle strobe; captures digits_in, dp_in, blank_in, lz_suppress.
REQ-011 SHALL have port segments  output  7  active-low segments, bit6 = a ... bit0 = g.
REQ-012 SHALL have port dp_out  output  1  active-low decimal point.
REQ-013 SHALL have port anodes  output  N_DIGITS  active-low digit enables, one-hot-low or all high.
REQ-014 SHALL have port frame_start  output  1  one-cycle pulse when digit 0's slot begins.

Function
REQ-015 SHALL run prescaler cnt 0..REFRESH_DIV-1, wrapping to 0; tick = (cnt == REFRESH_DIV-1).
REQ-016 SHALL advance digit index idx on tick, wrapping N_DIGITS-1 -> 0; frame_end = tick && idx == N_DIGITS-1.
REQ-017 SHALL, on load, write staging registers and set pending; load while pending overwrites staging.
REQ-018 SHALL, on frame_end with pending, copy staging to display registers and clear pending.
REQ-019 SHALL, when load and frame_end coincide, copy the inputs of that cycle directly to display registers and clear pending.
REQ-020 SHALL decode nibbles active-low: 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000 7=0001111 8=0000000 9=0000100 A=0001000 b=1100000 C=0110001 d=1000010 E=0110000 F=0111000.
REQ-021 SHALL, with lz_suppress set, blank each digit k >= 1 whose nibble and every higher nibble are 0; digit 0 never suppressed.
REQ-022 SHALL show a blanked digit (blank_in or suppressed) as segments=1111111, dp_out=1, anode still enabled.
REQ-023 SHALL drive anodes all high while cnt < BLANK_CYCLES, else anodes[idx] low only.
REQ-024 SHALL register segments, dp_out, anodes, frame_start: outputs reflect cnt/idx of the previous cycle (1-cycle latency).
REQ-025 SHALL pulse frame_start for the cycle after cnt==0 with idx==0 is evaluated.

Reset
REQ-026 SHALL on reset clear cnt, idx, pending, staging and display registers to 0.
REQ-027 SHALL on reset drive anodes all 1, segments 1111111, dp_out 1, frame_start 0.
REQ-028 SHALL make reset override load, tick and frame_end in the same cycle; mid-frame reset restarts at digit 0, cnt 0.

Structure
REQ-029 SHALL place SEG_OFF constant, 16-entry hex segment table and decode function in package seven_seg_pkg.
REQ-030 SHALL instantiate one combinational sub-module hex_to_seg7 (4-bit in, 7-bit active-low out) using that package.

Verification (N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-031 SHALL check reset: after release, anodes=1111, segments=1111111; first frame_start 1 cycle after release, anodes 1110 from cycle 3.
REQ-032 SHALL check load 16'h12AF, lz off: slots show 0111000, 0001000, 0010010, 1001111 on anodes 1110,1101,1011,0111.
REQ-033 SHALL check lz_suppress with 16'h0050: digits 3,2 dark; digit 1 = 0100100; digit 0 = 0000001; 16'h0000 shows only digit 0 = 0000001.
REQ-034 SHALL check load mid-frame: display changes only at next digit-0 slot; load on frame_end cycle appears in the immediately following slot.
REQ-035 SHALL check dp_in=4'b0100, blank_in=4'b0001: dp_out=0 only in digit-2 slot; digit 0 segments=1111111.
REQ-036 SHALL check reset asserted during digit-2 slot: next cycle outputs at reset values, scan resumes at digit 0.
